// File: rtl/pq_pkg.sv
// pq_pkg: shared key-value types and command encoding for the register-array
// priority queue and its command front-end.
package pq_pkg;
    localparam int KEY_W       = 8;
    localparam int VAL_W       = 8;
    localparam int PQ_CAPACITY = 4;
    localparam logic [KEY_W-1:0] KEY0   = '0;
    localparam logic [KEY_W-1:0] KEYINF = '1;
    localparam logic [VAL_W-1:0] VAL0   = '0;
    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [VAL_W-1:0] val;
    } kv_t;
    typedef enum logic [1:0] {NOP = 2'd0, ENQ = 2'd1, DEQ = 2'd2, REPL = 2'd3} pq_op_t;
    typedef struct packed {
        pq_op_t op;
        kv_t    kv;
    } pq_cmd_t;
    function automatic kv_t kv_inf();
        return '{key: KEYINF, val: VAL0};
    endfunction
endpackage

// File: rtl/pq_rd_fe_if.sv
// pq_rd_fe_if: command and response valid/ready streams of the queue front-end.
interface pq_rd_fe_if;
    import pq_pkg::*;
    logic   cmd_valid;
    logic   cmd_ready;
    pq_op_t cmd_op;
    kv_t    cmd_kv;
    logic   rsp_valid;
    logic   rsp_ready;
    logic   rsp_err;
    kv_t    rsp_kv;
    modport master (output cmd_valid, cmd_op, cmd_kv, rsp_ready,
                    input  cmd_ready, rsp_valid, rsp_err, rsp_kv);
    modport slave  (input  cmd_valid, cmd_op, cmd_kv, rsp_ready,
                    output cmd_ready, rsp_valid, rsp_err, rsp_kv);
endinterface

// File: rtl/pq_cmd_fifo.sv
// pq_cmd_fifo: synchronous command FIFO; full/empty come from pointers carrying
// one extra wrap bit.
module pq_cmd_fifo
    import pq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  pq_cmd_t din,
    input  logic    pop,
    output pq_cmd_t dout,
    output logic    full,
    output logic    empty
);
    localparam int AW = $clog2(DEPTH);
    pq_cmd_t mem [DEPTH];
    logic [AW:0] wp, rp;
    assign empty = wp == rp;
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign dout  = mem[rp[AW-1:0]];
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) begin
                mem[wp[AW-1:0]] <= din;
                wp <= wp + 1'b1;
            end
            if (pop && !empty)
                rp <= rp + 1'b1;
        end
    end
endmodule

// File: rtl/pq_rd_fe.sv
// pq_rd_fe: command front-end for the replace/dequeue priority queue; buffers
// commands, issues at most one legal queue op per cycle and returns responses.
module pq_rd_fe
    import pq_pkg::*;
#(
    parameter int CAPACITY  = PQ_CAPACITY,
    parameter int CMD_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    pq_rd_fe_if.slave                     bus,
    output logic                          pq_replace,
    output logic                          pq_deq,
    output kv_t                           pq_kvi,
    input  kv_t                           pq_kvo,
    input  logic                          pq_full,
    input  logic                          pq_empty,
    output logic [$clog2(CAPACITY+1)-1:0] real_cnt,
    output logic                          fill_phase,
    output logic                          sync_err
);
    localparam int CW = $clog2(CAPACITY+1);
    logic [CW-1:0] dummy_cnt;
    pq_cmd_t cmd_in, head;
    logic f_full, f_empty, issue, live, enq_ok, deq_ok, repl_ok;
    assign cmd_in = '{op: bus.cmd_op, kv: bus.cmd_kv};
    pq_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.cmd_valid),
        .din   (cmd_in),
        .pop   (issue),
        .dout  (head),
        .full  (f_full),
        .empty (f_empty)
    );
    assign bus.cmd_ready = !f_full;
    assign fill_phase    = dummy_cnt != '0;
    assign live          = real_cnt != '0;
    assign issue         = !f_empty && (!bus.rsp_valid || bus.rsp_ready);
    // Dummies must all be displaced before any real entry can leave the queue.
    assign enq_ok        = head.op == ENQ  && fill_phase;
    assign deq_ok        = head.op == DEQ  && !fill_phase && live;
    assign repl_ok       = head.op == REPL && !fill_phase && live;
    assign pq_replace    = issue && (enq_ok || repl_ok);
    assign pq_deq        = issue && deq_ok;
    assign pq_kvi        = head.kv;
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_kv    <= kv_inf();
            dummy_cnt     <= CW'(CAPACITY);
            real_cnt      <= '0;
            sync_err      <= 1'b0;
        end else begin
            if (issue && head.op != NOP) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_err   <= !(enq_ok || deq_ok || repl_ok);
                bus.rsp_kv    <= (deq_ok || repl_ok) ? pq_kvo : kv_inf();
            end else if (bus.rsp_ready) begin
                bus.rsp_valid <= 1'b0;
            end
            if (issue && enq_ok) begin
                dummy_cnt <= dummy_cnt - 1'b1;
                real_cnt  <= real_cnt + 1'b1;
            end
            if (pq_deq)
                real_cnt <= real_cnt - 1'b1;
            if (pq_full == fill_phase || (!fill_phase && pq_empty == live))
                sync_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pq_rd_fe.sv
// tb_pq_rd_fe: drives the front-end against a behavioural min-queue and checks
// responses and counters against a command-level reference model.
module tb_pq_rd_fe;
    import pq_pkg::*;
    localparam int CAP = 4;
    typedef struct {
        logic err;
        kv_t  kv;
    } exp_t;
    logic clk = 0, rst = 1;
    logic pq_replace, pq_deq, pq_full, pq_empty, fill_phase, sync_err;
    kv_t pq_kvi, pq_kvo;
    logic [$clog2(CAP+1)-1:0] real_cnt;
    int vectors = 0, miscompares = 0;
    int obs_ops = 0, exp_ops = 0, m_dummy = CAP;
    int m_keys[$];
    exp_t exp_q[$];
    logic rnd_en = 0;
    kv_t pq_arr [CAP];
    int mi;
    pq_rd_fe_if bus();
    pq_rd_fe #(.CAPACITY(CAP), .CMD_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .pq_replace (pq_replace),
        .pq_deq     (pq_deq),
        .pq_kvi     (pq_kvi),
        .pq_kvo     (pq_kvo),
        .pq_full    (pq_full),
        .pq_empty   (pq_empty),
        .real_cnt   (real_cnt),
        .fill_phase (fill_phase),
        .sync_err   (sync_err)
    );
    always #5 clk = ~clk;
    // Device-side queue: each op removes the smallest entry and writes the new one.
    always_comb begin
        mi = 0;
        for (int i = 1; i < CAP; i++)
            if (pq_arr[i].key < pq_arr[mi].key) mi = i;
    end
    assign pq_kvo   = pq_arr[mi];
    assign pq_full  = pq_kvo.key != KEY0;
    assign pq_empty = pq_kvo.key == KEYINF;
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CAP; i++) pq_arr[i] <= '{key: KEY0, val: VAL0};
            obs_ops <= 0;
        end else if (pq_replace || pq_deq) begin
            pq_arr[mi] <= pq_replace ? pq_kvi : kv_inf();
            obs_ops <= obs_ops + 1;
        end
    end
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic kv_t mk(input int k);
        kv_t r;
        r.key = 8'(k);
        r.val = 8'(k) ^ 8'hA5;
        return r;
    endfunction
    function automatic kv_t pop_min();
        m_keys.sort();
        return kv_t'(16'(m_keys.pop_front()));
    endfunction
    function automatic void model_accept(input pq_op_t op, input kv_t kv);
        exp_t e;
        e.err = 1'b1;
        e.kv  = kv_inf();
        if (op == NOP) return;
        if (op == ENQ && m_dummy > 0) begin
            m_dummy--;
            m_keys.push_back(int'(kv));
            e.err = 1'b0;
        end else if (op != ENQ && m_dummy == 0 && m_keys.size() > 0) begin
            e.kv = pop_min();
            if (op == REPL) m_keys.push_back(int'(kv));
            e.err = 1'b0;
        end
        if (!e.err) exp_ops++;
        exp_q.push_back(e);
    endfunction
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (!rst) begin
            if (pq_replace || pq_deq) check("pq_excl", 32'(pq_replace & pq_deq), 32'd0);
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                    check("rsp_kv", 32'(bus.rsp_kv), 32'(e.kv));
                end
            end
        end
    end
    always @(negedge clk) if (rnd_en) bus.rsp_ready = 1'($urandom_range(0, 1));
    task automatic send(input pq_op_t op, input kv_t kv);
        int t = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_kv    = kv;
        while (!bus.cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.cmd_ready) check("cmd_ready_timeout", 32'(bus.cmd_ready), 32'd1);
        else model_accept(op, kv);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask
    task automatic do_reset();
        rnd_en = 0;
        rst = 1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        rst = 0;
        bus.rsp_ready = 1'b1;
        exp_q.delete();
        m_keys.delete();
        m_dummy = CAP;
        exp_ops = 0;
        #1;
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_real_cnt", 32'(real_cnt), 32'd0);
        check("rst_fill_phase", 32'(fill_phase), 32'd1);
        check("rst_sync_err", 32'(sync_err), 32'd0);
        check("rst_pq_ops", 32'({pq_replace, pq_deq}), 32'd0);
        @(negedge clk);
    endtask
    task automatic drain();
        int t = 0;
        while (exp_q.size() > 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        check("real_cnt", 32'(real_cnt), 32'(m_keys.size()));
        check("fill_phase", 32'(fill_phase), 32'(m_dummy != 0));
        check("sync_err", 32'(sync_err), 32'd0);
        check("pq_op_count", 32'(obs_ops), 32'(exp_ops));
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        int ks[4];
        bus.cmd_valid = 1'b0;
        bus.cmd_op = NOP;
        bus.cmd_kv = '0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        do_reset();
        // fill with 7,3,9,5 then drain in priority order; a fifth DEQ must fail
        ks = '{7, 3, 9, 5};
        foreach (ks[i]) send(ENQ, mk(ks[i]));
        drain();
        check("full_pq_full", 32'(pq_full), 32'd1);
        check("full_real_cnt", 32'(real_cnt), 32'd4);
        repeat (5) send(DEQ, mk(1));
        drain();
        check("empty_pq_empty", 32'(pq_empty), 32'd1);
        check("empty_real_cnt", 32'(real_cnt), 32'd0);
        // replace the head of a full queue
        do_reset();
        ks = '{9, 5, 3, 7};
        foreach (ks[i]) send(ENQ, mk(ks[i]));
        send(REPL, mk(6));
        repeat (4) send(DEQ, mk(1));
        drain();
        // DEQ/REPL rejected during fill phase
        do_reset();
        repeat (2) send(ENQ, mk($urandom_range(1, 254)));
        send(DEQ, mk(1));
        send(REPL, mk($urandom_range(1, 254)));
        send(ENQ, mk($urandom_range(1, 254)));
        drain();
        check("fill_real_cnt", 32'(real_cnt), 32'd3);
        // back-pressure: one response held, FIFO fills, then release
        do_reset();
        bus.rsp_ready = 1'b0;
        fork
            for (int i = 0; i < 6; i++) send(ENQ, mk($urandom_range(1, 254)));
            begin
                repeat (8) @(negedge clk);
                check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
                check("bp_rsp_kv", 32'(bus.rsp_kv), 32'(kv_inf()));
                check("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
                check("bp_real_cnt", 32'(real_cnt), 32'd1);
                bus.rsp_ready = 1'b1;
            end
        join
        drain();
        // randomized command streams with random response back-pressure
        for (int r = 0; r < 3; r++) begin
            do_reset();
            rnd_en = 1;
            for (int i = 0; i < 40; i++) begin
                send(pq_op_t'($urandom_range(0, 3)), mk($urandom_range(1, 254)));
                if ($urandom_range(0, 3) == 0) @(negedge clk);
            end
            rnd_en = 0;
            @(negedge clk);
            bus.rsp_ready = 1'b1;
            drain();
        end
        // reset with commands buffered, then refill and check the new head
        do_reset();
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(ENQ, mk(10 + i));
        do_reset();
        send(ENQ, mk(2));
        for (int i = 0; i < 3; i++) send(ENQ, mk($urandom_range(3, 254)));
        send(DEQ, mk(1));
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
